// File: rtl/pattern_pkg.sv
// Shared widths and scheduler state encoding for the
// pattern scheduler slice.
package pattern_pkg;

  localparam int RGB_W = 8;
  localparam int PIX_W = 24;

  localparam logic [1:0] SHOW    = 2'd0;
  localparam logic [1:0] PENDING = 2'd1;
  localparam logic [1:0] SWITCH  = 2'd2;

  function automatic logic [PIX_W-1:0] blank_pix(
    input logic             de,
    input logic [PIX_W-1:0] pix
  );
    return de ? pix : '0;
  endfunction

endpackage

// File: rtl/pattern_scheduler_if.sv
// Video-in / video-out bundle between the pattern bank,
// the scheduler and the HDMI encoder.
interface pattern_scheduler_if
  import pattern_pkg::*;
#(
  parameter int NUM_PAT = 4,
  parameter int SEL_W   = 2
) ();

  logic                     key_n;
  logic                     auto_en;
  logic                     in_hs;
  logic                     in_vs;
  logic                     in_de;
  logic [NUM_PAT*PIX_W-1:0] pat_rgb;
  logic                     hs;
  logic                     vs;
  logic                     de;
  logic [RGB_W-1:0]         rgb_r;
  logic [RGB_W-1:0]         rgb_g;
  logic [RGB_W-1:0]         rgb_b;
  logic [SEL_W-1:0]         pat_sel;
  logic                     switch_pulse;

  modport master (
    output key_n, auto_en, in_hs, in_vs, in_de, pat_rgb,
    input  hs, vs, de, rgb_r, rgb_g, rgb_b,
    input  pat_sel, switch_pulse
  );

  modport slave (
    input  key_n, auto_en, in_hs, in_vs, in_de, pat_rgb,
    output hs, vs, de, rgb_r, rgb_g, rgb_b,
    output pat_sel, switch_pulse
  );

endinterface

// File: rtl/pattern_scheduler_key_debounce.sv
// Push-button synchroniser and debouncer; emits one
// pulse per accepted press (accepted 1->0 transition).
module key_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  logic        sync1;
  logic        sync2;
  logic        stable;
  logic [19:0] cnt;
  logic        differ;
  logic        flip;

  assign differ = sync2 != stable;
  assign flip   = differ &&
                  (cnt == DEBOUNCE_CYCLES - 20'd1);

  // released (1) is the safe power-up level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= flip & ~sync2;
      if (flip) begin
        stable <= sync2;
        cnt    <= '0;
      end else if (differ) begin
        cnt <= cnt + 20'd1;
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/pattern_scheduler.sv
// Selects one of NUM_PAT pattern sources for the HDMI path;
// selection advances only on a vsync rising edge.
module pattern_scheduler
  import pattern_pkg::*;
#(
  parameter int          NUM_PAT         = 4,
  parameter int          SEL_W           = 2,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [7:0]  AUTO_FRAMES     = 8'd120
) (
  input logic                clk,
  input logic                rst_n,
  pattern_scheduler_if.slave bus
);

  logic             press;
  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [7:0]       fcnt;
  logic             fb;
  logic             auto_req;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_nx;
  logic [PIX_W-1:0] pix;
  logic             hs_q;
  logic             vs_q;
  logic             de_q;
  logic [PIX_W-1:0] rgb_q;
  logic             pulse_q;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (bus.key_n),
    .press (press)
  );

  // vs_q doubles as the previous-vsync sample
  assign fb       = bus.in_vs & ~vs_q;
  assign auto_req = fb & bus.auto_en &
                    (fcnt == AUTO_FRAMES - 8'd1);

  assign sel_nx = (sel_q == SEL_W'(NUM_PAT - 1)) ?
                  '0 : sel_q + SEL_W'(1);

  assign pix = bus.pat_rgb[PIX_W*int'(sel_q) +: PIX_W];

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == SHOW): begin
        if (auto_req)   state_nx = SWITCH;
        else if (press) state_nx = PENDING;
      end
      (state == PENDING): begin
        if (fb) state_nx = SWITCH;
      end
      (state == SWITCH): state_nx = SHOW;
      default:           state_nx = SHOW;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SHOW;
      fcnt    <= '0;
      sel_q   <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
      rgb_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state   <= state_nx;
      hs_q    <= bus.in_hs;
      vs_q    <= bus.in_vs;
      de_q    <= bus.in_de;
      rgb_q   <= blank_pix(bus.in_de, pix);
      pulse_q <= state == SWITCH;
      if (state == SWITCH) sel_q <= sel_nx;
      if (!bus.auto_en || state == SWITCH)
        fcnt <= '0;
      else if (fb)
        fcnt <= fcnt + 8'd1;
    end
  end

  assign bus.hs           = hs_q;
  assign bus.vs           = vs_q;
  assign bus.de           = de_q;
  assign bus.rgb_r        = rgb_q[2*RGB_W +: RGB_W];
  assign bus.rgb_g        = rgb_q[RGB_W +: RGB_W];
  assign bus.rgb_b        = rgb_q[0 +: RGB_W];
  assign bus.pat_sel      = sel_q;
  assign bus.switch_pulse = pulse_q;

endmodule
